// File: rtl/bus_arbiter_if.sv
// Shared-bus request/grant bundle between the two requesters and the arbiter.
interface bus_arbiter_if;
    logic [1:0] REQ;
    logic [1:0] GNT;
    logic       BUSY;
    logic       PREEMPT;
    logic       OWNER;

    modport master (output REQ, input GNT, BUSY, PREEMPT, OWNER);
    modport slave  (input REQ, output GNT, BUSY, PREEMPT, OWNER);
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter with a hold limit and idle turnaround
// between owners. All outputs are registered.
module bus_arbiter #(
    parameter int unsigned MAX_HOLD   = 4,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic          CLK,
    input  logic          RST,
    bus_arbiter_if.slave  bus
);
    localparam int unsigned HOLD_W = ($clog2(MAX_HOLD + 1) > 1) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int unsigned TURN_W = ($clog2(TURNAROUND + 1) > 1) ? $clog2(TURNAROUND + 1) : 1;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TURN} state_e;

    state_e            state_q,   state_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic [TURN_W-1:0] turn_q,    turn_d;
    logic              prio_q,    prio_d;
    logic [1:0]        gnt_q,     gnt_d;
    logic              busy_q,    busy_d;
    logic              preempt_q, preempt_d;
    logic              owner_q,   owner_d;

    logic cur;
    logic release_req;
    logic decide;
    logic arb_idx;
    logic hold_sat;

    // Next-state, counters and registered outputs.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        turn_d      = turn_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        preempt_d   = 1'b0;
        release_req = 1'b0;
        decide      = 1'b0;
        cur         = (state_q == GRANT1);
        hold_sat    = (hold_q == HOLD_W'(MAX_HOLD));
        arb_idx     = (bus.REQ == 2'b11) ? prio_q : bus.REQ[1];

        case (state_q)
            IDLE: decide = 1'b1;
            GRANT0, GRANT1: begin
                if (!bus.REQ[cur]) begin
                    release_req = 1'b1;
                end else if ((MAX_HOLD != 0) && hold_sat && bus.REQ[~cur]) begin
                    release_req = 1'b1;
                    preempt_d   = 1'b1;
                end else if ((MAX_HOLD != 0) && !hold_sat) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            TURN: begin
                if (turn_q == TURN_W'(TURNAROUND)) begin
                    decide = 1'b1;
                end else begin
                    turn_d = turn_q + TURN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A release either opens a turnaround gap or hands over immediately.
        if (release_req) begin
            if (TURNAROUND > 0) begin
                state_d = TURN;
                turn_d  = TURN_W'(1);
                gnt_d   = 2'b00;
            end else begin
                decide = 1'b1;
            end
        end

        if (decide) begin
            if (|bus.REQ) begin
                state_d = arb_idx ? GRANT1 : GRANT0;
                gnt_d   = arb_idx ? 2'b10 : 2'b01;
                hold_d  = HOLD_W'(1);
                owner_d = arb_idx;
                prio_d  = ~arb_idx;
            end else begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        end

        busy_d = |gnt_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            turn_q    <= '0;
            prio_q    <= 1'b0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            owner_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            prio_q    <= prio_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
            owner_q   <= owner_d;
        end
    end

    assign bus.GNT     = gnt_q;
    assign bus.BUSY    = busy_q;
    assign bus.PREEMPT = preempt_q;
    assign bus.OWNER   = owner_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic on two
// configurations (hold 4 / gap 1, and hold 0 / gap 0) against a behavioural model.
module tb_bus_arbiter;
    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    bus_arbiter_if ia ();
    bus_arbiter_if ib ();

    bus_arbiter #(.MAX_HOLD(4), .TURNAROUND(1)) u_dut_a (.CLK(CLK), .RST(RST), .bus(ia.slave));
    bus_arbiter #(.MAX_HOLD(0), .TURNAROUND(0)) u_dut_b (.CLK(CLK), .RST(RST), .bus(ib.slave));

    // Model: owner (-1 = none), consecutive grant cycles, idle gap cycles left.
    int mh[2] = '{4, 0};
    int ta[2] = '{1, 0};
    int m_owner[2];
    int m_hold[2];
    int m_gap[2];
    int m_prio[2];
    int m_last[2];
    bit m_pre[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_hold[k] = 0; m_gap[k] = 0;
            m_prio[k]  = 0;  m_last[k] = 0; m_pre[k] = 1'b0;
        end
    endtask

    task automatic model_decide(input int k, input logic [1:0] r);
        int p;
        p = (r == 2'b11) ? m_prio[k] : (r[1] ? 1 : (r[0] ? 0 : -1));
        if (p >= 0) begin
            m_owner[k] = p; m_hold[k] = 1; m_last[k] = p; m_prio[k] = 1 - p;
        end else begin
            m_owner[k] = -1;
        end
    endtask

    task automatic model_step(input int k, input logic [1:0] r);
        int  o;
        bit  rel;
        m_pre[k] = 1'b0;
        if (m_owner[k] >= 0) begin
            o   = m_owner[k];
            rel = 1'b0;
            if (!r[o]) rel = 1'b1;
            else if (mh[k] != 0 && m_hold[k] == mh[k] && r[1-o]) begin
                rel = 1'b1; m_pre[k] = 1'b1;
            end else if (m_hold[k] < mh[k]) m_hold[k]++;
            if (rel) begin
                if (ta[k] > 0) begin m_owner[k] = -1; m_gap[k] = ta[k]; end
                else model_decide(k, r);
            end
        end else if (m_gap[k] > 0) begin
            if (m_gap[k] == 1) begin m_gap[k] = 0; model_decide(k, r); end
            else m_gap[k]--;
        end else begin
            model_decide(k, r);
        end
    endtask

    function automatic logic [1:0] exp_gnt(input int k);
        return (m_owner[k] < 0) ? 2'b00 : ((m_owner[k] == 1) ? 2'b10 : 2'b01);
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_step(0, ia.REQ);
        model_step(1, ib.REQ);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        #2;
        RST = 1'b0;
    endtask

    // Structural invariants on every cycle out of reset.
    always @(negedge CLK) begin
        if (!RST) begin
            checks++;
            if (ia.GNT == 2'b11 || ib.GNT == 2'b11 || ia.BUSY !== (|ia.GNT) || ib.BUSY !== (|ib.GNT)) begin
                errors++;
                $display("FAIL invariant: gnt_a=%b busy_a=%b gnt_b=%b busy_b=%b", ia.GNT, ia.BUSY, ib.GNT, ib.BUSY);
            end
        end
    end

    task automatic test_reset();
        do_reset();
        checks++;
        if (ia.GNT !== 2'b00 || ia.BUSY !== 1'b0 || ia.PREEMPT !== 1'b0 || ia.OWNER !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: gnt=%b busy=%b pre=%b own=%b want 00 0 0 0", ia.GNT, ia.BUSY, ia.PREEMPT, ia.OWNER);
        end
        ia.REQ = 2'b01;
        tick(); tick();
        checks++;
        if (ia.GNT !== 2'b01) begin
            errors++; $display("FAIL reset_pregrant: gnt=%b want 01", ia.GNT);
        end
        #3 RST = 1'b1;
        model_reset();
        #1;
        checks++;
        if (ia.GNT !== 2'b00 || ia.BUSY !== 1'b0 || ia.PREEMPT !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: gnt=%b busy=%b pre=%b want 00 0 0", ia.GNT, ia.BUSY, ia.PREEMPT);
        end
        #1 RST = 1'b0;
        ia.REQ = 2'b11;
        tick();
        checks++;
        if (ia.GNT !== 2'b01 || ia.OWNER !== 1'b0) begin
            errors++; $display("FAIL reset_prio0: gnt=%b own=%b want 01 0", ia.GNT, ia.OWNER);
        end
        ia.REQ = 2'b00;
    endtask

    task automatic test_single();
        do_reset();
        ia.REQ = 2'b10;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (ia.GNT !== 2'b10 || ia.PREEMPT !== 1'b0 || ia.OWNER !== 1'b1) begin
                errors++;
                $display("FAIL single_c%0d: gnt=%b pre=%b own=%b want 10 0 1", i, ia.GNT, ia.PREEMPT, ia.OWNER);
            end
        end
        ia.REQ = 2'b00;
        tick();
        checks++;
        if (ia.GNT !== 2'b00 || ia.PREEMPT !== 1'b0) begin
            errors++; $display("FAIL single_drop: gnt=%b pre=%b want 00 0", ia.GNT, ia.PREEMPT);
        end
    endtask

    task automatic test_contention();
        logic [1:0] eg;
        logic       ep;
        do_reset();
        ia.REQ = 2'b11;
        for (int i = 0; i < 20; i++) begin
            tick();
            case (i % 10)
                0, 1, 2, 3: begin eg = 2'b01; ep = 1'b0; end
                4, 9:       begin eg = 2'b00; ep = 1'b1; end
                default:    begin eg = 2'b10; ep = 1'b0; end
            endcase
            checks++;
            if (ia.GNT !== eg || ia.PREEMPT !== ep) begin
                errors++;
                $display("FAIL contention_c%0d: gnt=%b pre=%b want %b %b", i, ia.GNT, ia.PREEMPT, eg, ep);
            end
            checks++;
            if (ia.GNT !== exp_gnt(0) || ia.PREEMPT !== m_pre[0]) begin
                errors++;
                $display("FAIL contention_model_c%0d: gnt=%b pre=%b model %b %b", i, ia.GNT, ia.PREEMPT, exp_gnt(0), m_pre[0]);
            end
        end
        ia.REQ = 2'b00;
    endtask

    task automatic test_voluntary();
        do_reset();
        ia.REQ = 2'b01;
        tick();
        ia.REQ = 2'b11;
        tick();
        checks++;
        if (ia.GNT !== 2'b01) begin
            errors++; $display("FAIL voluntary_hold: gnt=%b want 01", ia.GNT);
        end
        ia.REQ = 2'b10;
        tick();
        checks++;
        if (ia.GNT !== 2'b00 || ia.PREEMPT !== 1'b0) begin
            errors++; $display("FAIL voluntary_gap: gnt=%b pre=%b want 00 0", ia.GNT, ia.PREEMPT);
        end
        tick();
        checks++;
        if (ia.GNT !== 2'b10 || ia.PREEMPT !== 1'b0) begin
            errors++; $display("FAIL voluntary_handover: gnt=%b pre=%b want 10 0", ia.GNT, ia.PREEMPT);
        end
        ia.REQ = 2'b00;
    endtask

    task automatic test_back_to_back();
        do_reset();
        ib.REQ = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ib.GNT !== 2'b01 || ib.PREEMPT !== 1'b0) begin
                errors++; $display("FAIL b2b_hold_c%0d: gnt=%b pre=%b want 01 0", i, ib.GNT, ib.PREEMPT);
            end
        end
        ib.REQ = 2'b10;
        tick();
        checks++;
        if (ib.GNT !== 2'b10 || ib.PREEMPT !== 1'b0 || ib.OWNER !== 1'b1) begin
            errors++; $display("FAIL b2b_direct: gnt=%b pre=%b own=%b want 10 0 1", ib.GNT, ib.PREEMPT, ib.OWNER);
        end
        ib.REQ = 2'b11;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (ib.GNT !== 2'b10 || ib.PREEMPT !== 1'b0) begin
                errors++; $display("FAIL b2b_nopreempt_c%0d: gnt=%b pre=%b want 10 0", i, ib.GNT, ib.PREEMPT);
            end
        end
        ib.REQ = 2'b00;
    endtask

    task automatic test_random();
        logic [1:0] r[2];
        logic [1:0] g;
        logic       p, o;
        do_reset();
        r[0] = 2'b00; r[1] = 2'b00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            for (int k = 0; k < 2; k++)
                for (int b = 0; b < 2; b++)
                    if (r[k][b]) r[k][b] = ($urandom_range(0, 5) != 0);
                    else         r[k][b] = ($urandom_range(0, 2) == 0);
            ia.REQ = r[0];
            ib.REQ = r[1];
            tick();
            for (int k = 0; k < 2; k++) begin
                g = (k == 0) ? ia.GNT : ib.GNT;
                p = (k == 0) ? ia.PREEMPT : ib.PREEMPT;
                o = (k == 0) ? ia.OWNER : ib.OWNER;
                checks++;
                if (g !== exp_gnt(k) || p !== m_pre[k] || o !== m_last[k][0]) begin
                    errors++;
                    $display("FAIL random_d%0d_c%0d: gnt=%b pre=%b own=%b model %b %b %0d",
                             k, i, g, p, o, exp_gnt(k), m_pre[k], m_last[k]);
                end
            end
        end
        ia.REQ = 2'b00;
        ib.REQ = 2'b00;
    endtask

    initial begin
        RST    = 1'b1;
        ia.REQ = 2'b00;
        ib.REQ = 2'b00;
        model_reset();
        @(posedge CLK);
        #1 RST = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_voluntary();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-requester arbiter for the single shared memory/data bus of the processor.
- Requester 0 is the CPU core; requester 1 is a secondary master such as the DMA or video fetch unit.
- Grants are registered, one-hot and round-robin, with a programmable hold limit that forces release when the other side is waiting.
- A programmable idle turnaround is inserted between owners so bus drivers never overlap.

Parameters:
- MAX_HOLD, 4: maximum consecutive granted cycles before a contending requester preempts. 0 disables preemption.
- TURNAROUND, 1: idle cycles with no grant between any release and the next grant. 0 allows a direct handover on the next cycle.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous active-high reset.
- REQ  input  2  REQ[n] high requests the bus; the requester holds it high while it wants ownership.
- GNT  output 2  registered one-hot grant; GNT[n] high means requester n owns the bus. Never 2'b11.
- BUSY  output 1  high whenever GNT != 0.
- PREEMPT  output 1  one-cycle pulse in the first cycle after a grant is forcibly removed by the hold limit.
- OWNER  output 1  index of the current or most recent owner; valid while BUSY.

Behaviour:
- Reset (asynchronous, immediate on RST rising):
  - GNT=2'b00, BUSY=0, PREEMPT=0, OWNER=0.
  - State IDLE, hold counter 0, priority pointer PRIO=0 (requester 0 favoured first).
- Reset may land mid-grant: grant drops immediately and no pending state survives.
- States: IDLE, GRANT0, GRANT1, TURN.
- Arbitration decision, evaluated in IDLE and at the end of TURN:
  - Only REQ[n] high: grant n.
  - Both high: grant PRIO.
  - Neither high: go to IDLE.
  - GNT asserts on the clock edge after REQ is sampled high: 1-cycle latency from IDLE.
- On entering GRANTn:
  - Hold counter reset to 1.
  - OWNER=n.
  - PRIO set to the other index (1-n), so the next contention favours the other requester.
- GRANTn, evaluated each cycle:
  - REQ[n] low: release.
  - Otherwise, if MAX_HOLD!=0 and counter==MAX_HOLD and REQ[1-n] high: preempt (release and pulse PREEMPT next cycle).
  - Otherwise stay; counter increments and saturates at MAX_HOLD.
- Without contention a grant persists indefinitely.
- Release path:
  - TURNAROUND>0: go to TURN, GNT=0 for exactly TURNAROUND cycles (turnaround counter), then apply the arbitration decision.
  - TURNAROUND==0: apply the arbitration decision immediately. A back-to-back handover is allowed, but GNT still switches atomically, never showing both bits.
- A preempted requester that keeps REQ high is re-granted once the other releases or is itself preempted; no request is lost.
- Simultaneous events:
  - REQ[n] drop in the same cycle the hold limit is hit: treated as a normal release, no PREEMPT.
  - Both requests rising in the same IDLE cycle: PRIO decides.
  - A requester asserting REQ during TURN is considered at the end of TURN.
- A requester must hold REQ until granted. A REQ that drops before grant is simply not granted, and the arbiter never glitches GNT.
- Counter width is max(1, clog2(MAX_HOLD+1)) bits.
- Turnaround counter width is max(1, clog2(TURNAROUND+1)) bits.

Test Plan:
- Reset state:
  - Stimulus: RST=1 mid-grant with GNT=2'b01.
  - Response: GNT=00, BUSY=0, PREEMPT=0 before the next CLK edge. After release, REQ=2'b11 grants GNT=2'b01 (PRIO=0).
- Single requester:
  - Stimulus: REQ=2'b10 for 10 cycles, then 00.
  - Response: GNT=2'b10 from cycle 1 through cycle 10; never preempted, PREEMPT stays 0. GNT=00 one cycle after REQ drops.
- Contention preemption (MAX_HOLD=4, TURNAROUND=1):
  - Stimulus: REQ=2'b11 held.
  - Response (periodic):
    - GNT=01 for 4 cycles, then 00 for 1 cycle with PREEMPT=1.
    - Then 10 for 4 cycles, then 00 for 1 cycle with PREEMPT=1.
    - Repeats with period 10.
- Voluntary release:
  - Stimulus: GNT=01 at counter 2 when REQ[0] drops and REQ[1] is high.
  - Response: GNT=00 for 1 cycle, then 10; PREEMPT=0.
- TURNAROUND=0, MAX_HOLD=0:
  - Stimulus: REQ=11, then REQ[0] drops after 3 grant cycles.
  - Response: GNT goes 01 directly to 10 on the next edge with no gap. No preemption occurs while both are requesting.
- Invariant check (all runs): assert GNT!=2'b11 and BUSY==|GNT every cycle.
